// File: rtl/div_const_pkg.sv
// Shared constants, types and FSM encoding for the 60/47 digit-serial divider family.
package div_const_pkg;

  localparam int unsigned DIVIDEND_W = 60;
  localparam int unsigned DIGIT_W    = 6;
  localparam int unsigned DIVISOR    = 47;
  localparam int unsigned NDIG       = DIVIDEND_W / DIGIT_W;
  localparam int unsigned CNT_W      = $clog2(NDIG);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  typedef logic [DIGIT_W-1:0]   digit_t;
  typedef logic [DIGIT_W-1:0]   rem_t;
  typedef logic [2*DIGIT_W-1:0] step_in_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/div47_step.sv
// One radix-64 division step: {r, d} / 47 -> quotient digit and next remainder.
module div47_step
  import div_const_pkg::*;
(
  input  step_in_t i_step,
  output digit_t   o_qd,
  output rem_t     o_rem
);

  localparam step_in_t DivExt = step_in_t'(DIVISOR);

  step_in_t w_acc;

  // Compare-subtract chain; r < 47 on entry guarantees the quotient fits in DIGIT_W bits.
  always_comb begin
    w_acc = i_step;
    o_qd  = '0;
    for (int i = DIGIT_W - 1; i >= 0; i--) begin
      if (w_acc >= (DivExt << i)) begin
        w_acc   = w_acc - (DivExt << i);
        o_qd[i] = 1'b1;
      end
    end
  end

  assign o_rem = w_acc[DIGIT_W-1:0];

endmodule

// File: rtl/div47_digit_serial.sv
// Digit-serial 60-bit / 47 divider, MSB digit first, valid/ready on both sides.
// Define DIV_REM_OUT_EN to expose the final remainder on out_r.
module div47_digit_serial
  import div_const_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_q
`ifdef DIV_REM_OUT_EN
  ,
  output logic [DIGIT_W-1:0]    out_r
`endif
);

  state_t                r_state;
  state_t                w_state_next;
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVIDEND_W-1:0] r_quo;
  rem_t                  r_rem;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_out_valid;
  logic [DIVIDEND_W-1:0] r_out_q;
`ifdef DIV_REM_OUT_EN
  rem_t                  r_out_r;
`endif

  digit_t w_qd;
  rem_t   w_rem_next;
  logic   w_last;

  div47_step u_step (
    .i_step ({r_rem, r_shift[DIVIDEND_W-1 -: DIGIT_W]}),
    .o_qd   (w_qd),
    .o_rem  (w_rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_last       = (r_cnt == LAST_CNT);
    unique case (r_state)
      IDLE:    if (in_valid) w_state_next = BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
`ifdef DIV_REM_OUT_EN
      r_out_r     <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= in_x;
            r_rem   <= '0;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          r_shift <= r_shift << DIGIT_W;
          r_quo   <= {r_quo[DIVIDEND_W-DIGIT_W-1:0], w_qd};
          r_rem   <= w_rem_next;
          r_cnt   <= r_cnt + 1'b1;
          // Outputs only update on the final digit so they hold while out_valid is low.
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_q     <= {r_quo[DIVIDEND_W-DIGIT_W-1:0], w_qd};
`ifdef DIV_REM_OUT_EN
            r_out_r     <= w_rem_next;
`endif
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
`ifdef DIV_REM_OUT_EN
  assign out_r     = r_out_r;
`endif

endmodule

// File: tb/tb_div47_digit_serial.sv
// Self-checking bench for div47_digit_serial: directed table, handshake corner cases, random ops.
module tb_div47_digit_serial;

  // Accept cycle plus ten BUSY cycles: out_valid is seen ten edges after the accept edge.
  localparam int LatEdges = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_q;
`ifdef DIV_REM_OUT_EN
  logic [5:0]  out_r;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div47_digit_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q)
`ifdef DIV_REM_OUT_EN
    ,
    .out_r     (out_r)
`endif
  );

  typedef struct {
    logic [59:0] x;
    logic [59:0] q;
    logic [5:0]  r;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer x for one cycle; returns #1 after the accept edge.
  task automatic start_op(input logic [59:0] x);
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int          n;
    int          acc[$];
    logic [63:0] t;
    logic [59:0] x;
    logic [59:0] eq;
    bit          got;

    vecs[0] = '{x: 60'd0,     q: 60'd0,    r: 6'd0};
    vecs[1] = '{x: 60'd1000,  q: 60'd21,   r: 6'd13};
    vecs[2] = '{x: 60'd47,    q: 60'd1,    r: 6'd0};
    vecs[3] = '{x: 60'd46,    q: 60'd0,    r: 6'd46};
    vecs[4] = '{x: {60{1'b1}}, q: 60'd24530244778869084, r: 6'd27};
    vecs[5] = '{x: 60'd94,    q: 60'd2,    r: 6'd0};
    vecs[6] = '{x: 60'd3007,  q: 60'd63,   r: 6'd46};
    vecs[7] = '{x: 60'd12345, q: 60'd262,  r: 6'd31};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_q", {4'd0, out_q}, 64'd0);
`ifdef DIV_REM_OUT_EN
    chk("rst_out_r", {58'd0, out_r}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed table with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].x);
      wait_valid(n);
      chk("tbl_latency", 64'(n), 64'(LatEdges));
      chk("tbl_q", {4'd0, out_q}, {4'd0, vecs[i].q});
`ifdef DIV_REM_OUT_EN
      chk("tbl_r", {58'd0, out_r}, {58'd0, vecs[i].r});
`endif
      @(posedge clk);
      #1;
      chk("tbl_drained", {63'd0, out_valid}, 64'd0);
      chk("tbl_hold_q", {4'd0, out_q}, {4'd0, vecs[i].q});
    end

    // Backpressure: result must hold and new offers must be ignored.
    @(negedge clk);
    out_ready = 1'b0;
    start_op(60'd1000);
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'(LatEdges));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = 60'd47;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_q", {4'd0, out_q}, 64'd21);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef DIV_REM_OUT_EN
      chk("bp_out_r", {58'd0, out_r}, 64'd13);
`endif
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_release_q", {4'd0, out_q}, 64'd21);

    // Throughput: back-to-back offers with out_ready high are accepted every 12 cycles.
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 60'd1000;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) acc.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("thru_count", 64'(acc.size()), 64'd4);
    if (acc.size() >= 2) chk("thru_period", 64'(acc[1] - acc[0]), 64'd12);
    chk("thru_q", {4'd0, out_q}, 64'd21);

    // Reset during BUSY cycle 5 aborts the operation.
    start_op(60'd12345);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_q", {4'd0, out_q}, 64'd0);
`ifdef DIV_REM_OUT_EN
    chk("midrst_out_r", {58'd0, out_r}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_result", {63'd0, out_valid}, 64'd0);
    start_op(60'd94);
    wait_valid(n);
    chk("postrst_latency", 64'(n), 64'(LatEdges));
    chk("postrst_q", {4'd0, out_q}, 64'd2);
    @(posedge clk);
    #1;

    // Random dividends with random out_ready; each op must hand over exactly one result.
    for (int k = 0; k < 2000; k++) begin
      t = {$urandom(), $urandom()};
      x = t[59:0];
      if (k == 0) x = {60{1'b1}};
      if (k == 1) x = '0;
      eq = x / 60'd47;
      start_op(x);
      got = 1'b0;
      n   = 0;
      while (!got && n < 200) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 1) == 1);
        if (out_valid && out_ready) begin
          got = 1'b1;
          chk("rand_q", {4'd0, out_q}, {4'd0, eq});
`ifdef DIV_REM_OUT_EN
          chk("rand_r", {58'd0, out_r}, {4'd0, x - eq * 60'd47});
          chk("rand_r_lt47", {63'd0, (out_r < 6'd47)}, 64'd1);
`endif
        end
        @(posedge clk);
        #1;
        n++;
      end
      chk("rand_handshake", {63'd0, got}, 64'd1);
      chk("rand_no_dup", {63'd0, out_valid}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
             n_tests, n_fail);
    $fatal(1);
  end

endmodule
